tagged_array_ctrl: RTL

TAGGED_ARRAY_CTRL -- requirements
Module: tagged_array_ctrl

---
 rtl/tagged_array_pkg.sv | 26 ++
 rtl/tagged_array_ctrl_rr_arb2.sv | 35 +++
 rtl/tagged_array_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/tagged_array_pkg.sv
// Shared types and defaults for the tagged array controller.
// TAG_SCRUB_EN adds the SCRUB state used by H->L retags.
package tagged_array_pkg;

    localparam int DEPTH_DEF  = 16;
    localparam int DATA_W_DEF = 3;

    localparam logic TAG_L = 1'b0;
    localparam logic TAG_H = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef TAG_SCRUB_EN
        ST_SCRUB = 2'd2,
`endif
        ST_RETAG = 2'd1
    } rt_state_t;

    function automatic logic is_downgrade(
        input logic cur,
        input logic nxt
    );
        return (cur == TAG_H) && (nxt == TAG_L);
    endfunction

endpackage

// File: rtl/tagged_array_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter.
// Bit 0 is the low writer, bit 1 the high writer.
module rr_arb2
    import tagged_array_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio_hi_q;

    // one-hot grant, contention resolved by the priority pointer
    always_comb begin
        gnt = 2'b00;
        if (req[0] && req[1]) begin
            gnt = prio_hi_q ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    // pointer moves to the writer that did not get the grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_hi_q <= 1'b0;
        end else if (gnt[0]) begin
            prio_hi_q <= 1'b1;
        end else if (gnt[1]) begin
            prio_hi_q <= 1'b0;
        end
    end

endmodule

// File: rtl/tagged_array_ctrl.sv
// Tagged array with two arbitrated writers, a read port and a retag FSM.
// Define TAG_SCRUB_EN to allow H->L retags through a data scrub.
module tagged_array_ctrl
    import tagged_array_pkg::*;
#(
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int IW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_lo_valid,
    input  logic [IW-1:0]     wr_lo_idx,
    input  logic [DATA_W-1:0] wr_lo_data,
    output logic              wr_lo_ready,
    input  logic              wr_hi_valid,
    input  logic [IW-1:0]     wr_hi_idx,
    input  logic [DATA_W-1:0] wr_hi_data,
    output logic              wr_hi_ready,
    output logic              wr_hi_err,
    input  logic              rd_valid,
    input  logic [IW-1:0]     rd_idx,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_tag,
    input  logic              rt_valid,
    input  logic [IW-1:0]     rt_idx,
    input  logic              rt_tag,
    output logic              rt_ready,
    output logic              rt_done,
    output logic              rt_nack,
    output logic              busy
);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  tag_q;

    rt_state_t   state_q;
    logic [IW-1:0] lock_idx_q;
    logic        new_tag_q;
    logic        rt_ready_q;
    logic        busy_q;
    logic        rt_done_q;
    logic        rt_nack_q;
    logic        hi_err_q;

    logic              rd_dv_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_tag_q;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       locked;
    logic       lo_hit;
    logic       hi_hit;
    logic       lo_fire;
    logic       hi_fire;
    logic       hi_ok;
    logic       rt_accept;
    logic       downgrade;

    assign req = {wr_hi_valid, wr_lo_valid};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign locked  = (state_q != ST_IDLE);
    assign lo_hit  = locked && (wr_lo_idx == lock_idx_q);
    assign hi_hit  = locked && (wr_hi_idx == lock_idx_q);

    assign wr_lo_ready = rst_n && gnt[0] && !lo_hit;
    assign wr_hi_ready = rst_n && gnt[1] && !hi_hit;

    assign lo_fire = wr_lo_valid && wr_lo_ready;
    assign hi_fire = wr_hi_valid && wr_hi_ready;
    assign hi_ok   = (tag_q[wr_hi_idx] == TAG_H);

    assign rt_accept = rt_valid && rt_ready_q;
    assign downgrade = is_downgrade(tag_q[rt_idx], rt_tag);

    // array update: one writer, plus scrub/retag on the locked entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            if (lo_fire) begin
                data_q[wr_lo_idx] <= wr_lo_data;
            end else if (hi_fire && hi_ok) begin
                data_q[wr_hi_idx] <= wr_hi_data;
            end
`ifdef TAG_SCRUB_EN
            if (state_q == ST_SCRUB) begin
                data_q[lock_idx_q] <= '0;
            end
`endif
            if (state_q == ST_RETAG) begin
                tag_q[lock_idx_q] <= new_tag_q;
            end
        end
    end

    // dropped high write flags an error on the next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_err_q <= 1'b0;
        end else begin
            hi_err_q <= hi_fire && !hi_ok;
        end
    end

    // registered read; a locked entry reads as zero data, H tag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_dv_q   <= 1'b0;
            rd_data_q <= '0;
            rd_tag_q  <= 1'b0;
        end else begin
            rd_dv_q <= rd_valid;
            if (rd_valid) begin
                if (locked && (rd_idx == lock_idx_q)) begin
                    rd_data_q <= '0;
                    rd_tag_q  <= TAG_H;
                end else begin
                    rd_data_q <= data_q[rd_idx];
                    rd_tag_q  <= tag_q[rd_idx];
                end
            end
        end
    end

    // retag FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lock_idx_q <= '0;
            new_tag_q  <= TAG_L;
            rt_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            rt_done_q  <= 1'b0;
            rt_nack_q  <= 1'b0;
        end else begin
            rt_done_q <= 1'b0;
            rt_nack_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    rt_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (rt_accept) begin
                        lock_idx_q <= rt_idx;
                        new_tag_q  <= rt_tag;
                        if (downgrade) begin
`ifdef TAG_SCRUB_EN
                            state_q    <= ST_SCRUB;
                            rt_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
`else
                            rt_nack_q  <= 1'b1;
`endif
                        end else begin
                            state_q    <= ST_RETAG;
                            rt_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
`ifdef TAG_SCRUB_EN
                ST_SCRUB: begin
                    state_q    <= ST_RETAG;
                    rt_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
`endif
                ST_RETAG: begin
                    state_q    <= ST_IDLE;
                    rt_done_q  <= 1'b1;
                    rt_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    rt_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign wr_hi_err     = hi_err_q;
    assign rd_data_valid = rd_dv_q;
    assign rd_data       = rd_data_q;
    assign rd_tag        = rd_tag_q;
    assign rt_ready      = rt_ready_q;
    assign rt_done       = rt_done_q;
    assign rt_nack       = rt_nack_q;
    assign busy          = busy_q;

endmodule
